j_bram_loader: RTL and testbench

// - Host-side writer for the annealer's coupling BRAM port (ena/wea/addra/dina).
// - Accepts a byte stream over a valid/ready handshake and unpacks each byte into
//   8/WIDTH J words.
// - Writes the words to consecutive BRAM addresses 0..N*N-1, then pulses comp_en
//   to start annealing.
// - Sits between the host link and the annealer top, and only loads while the

---
 rtl/ssqa_pkg.sv | 14 +
 rtl/j_bram_loader_if.sv | 16 +
 rtl/j_unpacker.sv | 35 +++
 rtl/j_bram_loader.sv | 138 +++++++++++++
 tb/tb_j_bram_loader.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssqa_pkg.sv
// rtl/ssqa_pkg.sv - shared scheduler constants, loader state encoding and helpers
package ssqa_pkg;

  localparam logic [3:0] SCHED_IDLE = 4'd0;
  localparam logic [3:0] SCHED_FIN  = 4'd10;

  typedef enum logic [2:0] {L_IDLE, L_RECV, L_WRITE, L_CKSUM, L_START} jload_state_t;

  // J words carried per stream byte
  function automatic int vpb(input int width);
    return 8 / width;
  endfunction

endpackage

// File: rtl/j_bram_loader_if.sv
// rtl/j_bram_loader_if.sv - byte stream in and coupling BRAM write port out
interface j_bram_loader_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 20
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WIDTH-1:0]  dina;

  modport master (output s_data, s_valid, input s_ready, ena, wea, addra, dina);
  modport slave  (input s_data, s_valid, output s_ready, ena, wea, addra, dina);
endinterface

// File: rtl/j_unpacker.sv
// rtl/j_unpacker.sv - holds one stream byte and presents its WIDTH-bit slices low first
module j_unpacker
  import ssqa_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] word,
  output logic             last
);
  localparam int VPB = vpb(WIDTH);
  localparam int K_W = (VPB > 1) ? $clog2(VPB) : 1;

  logic [7:0]     byte_q;
  logic [K_W-1:0] k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
      k      <= '0;
    end else if (load) begin
      byte_q <= data;
      k      <= '0;
    end else if (advance && !last) begin
      k <= k + K_W'(1);
    end
  end

  assign word = WIDTH'(byte_q >> (32'(k) * WIDTH));
  assign last = (k == K_W'(VPB - 1));
endmodule

// File: rtl/j_bram_loader.sv
// rtl/j_bram_loader.sv - streams J words into the coupling BRAM, then pulses comp_en
// Optional JLOAD_CKSUM_EN: checks a trailing 8-bit sum byte before starting the annealer.
module j_bram_loader
  import ssqa_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int N      = 800,
  parameter int ADDR_W = 20
) (
  input  logic             clk,
  input  logic             rst_sys,
  input  logic             load_start,
  input  logic [3:0]       sched_state,
  j_bram_loader_if.slave   bus,
  output logic             comp_en,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int TOTAL = N * N;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  jload_state_t      state, state_n;
  logic [ADDR_W-1:0] addr, addra_q;
  logic [WIDTH-1:0]  dina_q, word;
  logic              last_slice, start_ok, load_byte, wr;

  assign start_ok  = load_start && (sched_state == SCHED_IDLE || sched_state == SCHED_FIN);
  assign load_byte = (state == L_RECV) && bus.s_valid;

  j_unpacker #(.WIDTH(WIDTH)) u_unpack (
    .clk     (clk),
    .rst     (rst_sys),
    .load    (load_byte),
    .advance (wr),
    .data    (bus.s_data),
    .word    (word),
    .last    (last_slice)
  );

`ifdef JLOAD_CKSUM_EN
  logic [7:0] sum;
  logic       err_set;
`endif

  always_comb begin
    state_n     = state;
    bus.s_ready = 1'b0;
    wr          = 1'b0;
    comp_en     = 1'b0;
`ifdef JLOAD_CKSUM_EN
    err_set     = 1'b0;
`endif
    case (state)
      L_IDLE:  if (start_ok) state_n = L_RECV;
      L_RECV: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) state_n = L_WRITE;
      end
      L_WRITE: begin
        wr = 1'b1;
        // Terminal address wins over slice position: leftover slices are dropped
        if (addr == LAST_ADDR)
`ifdef JLOAD_CKSUM_EN
          state_n = L_CKSUM;
`else
          state_n = L_START;
`endif
        else if (last_slice)
          state_n = L_RECV;
      end
`ifdef JLOAD_CKSUM_EN
      L_CKSUM: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          if (bus.s_data == sum) begin
            state_n = L_START;
          end else begin
            err_set = 1'b1;
            state_n = L_IDLE;
          end
        end
      end
`endif
      L_START: begin
        comp_en = 1'b1;
        state_n = L_IDLE;
      end
      default: state_n = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      state   <= L_IDLE;
      addr    <= '0;
      addra_q <= '0;
      dina_q  <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == L_IDLE && start_ok) begin
        addr <= '0;
        done <= 1'b0;
      end
      if (wr) begin
        addr    <= addr + ADDR_W'(1);
        addra_q <= addr;
        dina_q  <= word;
      end
      if (comp_en) done <= 1'b1;
    end
  end

`ifdef JLOAD_CKSUM_EN
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      sum <= '0;
      err <= 1'b0;
    end else if (state == L_IDLE && start_ok) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (load_byte) sum <= sum + bus.s_data;
      if (err_set)   err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Write port shows the live word while writing and holds the last write otherwise
  assign bus.ena   = wr;
  assign bus.wea   = wr;
  assign bus.addra = wr ? addr : addra_q;
  assign bus.dina  = wr ? word : dina_q;
  assign busy      = (state != L_IDLE);
endmodule

// File: tb/tb_j_bram_loader.sv
// tb/tb_j_bram_loader.sv - scoreboard bench for j_bram_loader (WIDTH=4 N=4 and WIDTH=8 N=3)
module tb_j_bram_loader;
  import ssqa_pkg::*;

  localparam int W = 4, N = 4, AW = 20, TOTAL = N * N, VPB = 8 / W;
  localparam int NBYTES = (TOTAL + VPB - 1) / VPB;
  localparam int W2 = 8, N2 = 3, TOTAL2 = N2 * N2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load_start, load2;
  logic [3:0] sched_state;
  logic       comp_en, busy, done, err;
  logic       comp2, busy2, done2, err2;

  j_bram_loader_if #(.WIDTH(W), .ADDR_W(AW))  bus ();
  j_bram_loader_if #(.WIDTH(W2), .ADDR_W(AW)) bus2 ();

  j_bram_loader #(.WIDTH(W), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_sys(rst), .load_start(load_start), .sched_state(sched_state),
    .bus(bus), .comp_en(comp_en), .busy(busy), .done(done), .err(err));

  j_bram_loader #(.WIDTH(W2), .N(N2), .ADDR_W(AW)) dut2 (
    .clk(clk), .rst_sys(rst), .load_start(load2), .sched_state(sched_state),
    .bus(bus2), .comp_en(comp2), .busy(busy2), .done(done2), .err(err2));

  typedef struct packed {
    logic          is_start;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  int         checks = 0, errors = 0;
  int         wr_count = 0, hs_count = 0, w2cnt = 0, c2count = 0;
  logic       prev_wr = 1'b0;
  logic [AW-1:0] prev_a = '0;
  bit         abort = 0, gaps = 0;
  logic [7:0] rbytes[$];
  logic [7:0] bytes2[TOTAL2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: word i of the load is nibble (i % VPB) of byte (i / VPB), only for i < TOTAL
  task automatic model_load(input logic [7:0] bytes[$], input bit start);
    ev_t ev;
    for (int bi = 0; bi < bytes.size(); bi++) begin
      for (int k = 0; k < VPB; k++) begin
        int a;
        a = bi * VPB + k;
        if (a < TOTAL) begin
          ev.is_start = 1'b0;
          ev.a = AW'(a);
          ev.d = (bytes[bi] >> (k * W)) & 8'((1 << W) - 1);
          exp_q.push_back(ev);
        end
      end
    end
    if (start) begin
      ev = '0;
      ev.is_start = 1'b1;
      exp_q.push_back(ev);
    end
  endtask

  always @(posedge clk) if (!rst && bus.s_valid && bus.s_ready) hs_count++;

  always @(negedge clk) begin
    if (bus.ena || bus.wea || comp_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {bus.ena, bus.wea, comp_en}, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.is_start) begin
          chk("comp_en", {comp_en, bus.ena}, 2'b10);
`ifndef JLOAD_CKSUM_EN
          chk("start_after_last", {prev_wr, prev_a}, {1'b1, AW'(TOTAL - 1)});
`endif
        end else begin
          chk("write_strobes", {bus.ena, bus.wea, comp_en}, 3'b110);
          chk("addra", bus.addra, mon_ev.a);
          chk("dina", bus.dina, mon_ev.d);
          wr_count++;
        end
      end
    end
    prev_wr = bus.ena;
    prev_a  = bus.addra;
  end

  always @(negedge clk) begin
    if (bus2.ena) begin
      if (w2cnt < TOTAL2) begin
        chk("addra2", bus2.addra, w2cnt);
        chk("dina2", bus2.dina, bytes2[w2cnt]);
      end else begin
        chk("extra_write2", w2cnt, TOTAL2 - 1);
      end
      w2cnt++;
    end
    if (comp2) begin
      chk("comp2_after_last", w2cnt, TOTAL2);
      c2count++;
    end
  end

  task automatic send(input logic [7:0] bytes[$], input bit sel);
    int i = 0, cyc = 0;
    while (i < bytes.size() && !abort) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc > 2000) begin
        chk("send_timeout", i, bytes.size());
        break;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        if (sel) bus2.s_valid = 1'b0; else bus.s_valid = 1'b0;
      end else if (sel) begin
        bus2.s_valid = 1'b1; bus2.s_data = bytes[i];
        if (bus2.s_ready) i++;
      end else begin
        bus.s_valid = 1'b1; bus.s_data = bytes[i];
        if (bus.s_ready) i++;
      end
    end
    @(negedge clk); #1;
    bus.s_valid = 1'b0; bus2.s_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while ((sel ? busy2 : busy) && cyc < 200);
    if (cyc >= 200) chk("idle_timeout", cyc, 0);
  endtask

  task automatic do_load(input logic [7:0] bytes[$], input logic [3:0] sst, input bit bad);
    logic [7:0] sum = 8'd0;
    logic [7:0] tx[$];
    int hs0;
    foreach (bytes[i]) sum += bytes[i];
    tx = bytes;
`ifdef JLOAD_CKSUM_EN
    tx.push_back(sum + (bad ? 8'd1 : 8'd0));
`endif
    model_load(bytes, !bad);
    hs0 = hs_count;
    @(negedge clk); #1;
    sched_state = sst; load_start = 1'b1;
    @(negedge clk); #1;
    load_start = 1'b0;
    chk("busy_after_start", busy, 1);
    send(tx, 1'b0);
    wait_idle(1'b0);
    chk("done", done, !bad);
    chk("err", err, bad);
    chk("queue_drained", exp_q.size(), 0);
    chk("handshakes", hs_count - hs0, tx.size());
  endtask

  task automatic rand_bytes(output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < NBYTES; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int base, cyc, hs0;
    logic [7:0] sum2;
    rst = 1'b1; load_start = 1'b0; load2 = 1'b0; sched_state = 4'd0;
    bus.s_valid = 1'b0; bus.s_data = 8'd0; bus2.s_valid = 1'b0; bus2.s_data = 8'd0;
    #1;
    chk("reset_flags", {comp_en, busy, done, err, bus.ena, bus.wea, bus.s_ready}, 0);
    chk("reset_addra", bus.addra, 0);
    chk("reset_dina", bus.dina, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Fixed ascending stream, no gaps
    q = {};
    for (int i = 0; i < NBYTES; i++) q.push_back(8'(((2 * i + 1) << 4) | (2 * i)));
    gaps = 0;
    do_load(q, SCHED_IDLE, 1'b0);

    // Random data with random valid gaps, started from FIN
    gaps = 1;
    rand_bytes(q);
    do_load(q, SCHED_FIN, 1'b0);

    // Scheduler busy: load_start ignored even with data on offer
    hs0 = hs_count;
    @(negedge clk); #1;
    sched_state = 4'd3; load_start = 1'b1; bus.s_valid = 1'b1;
    @(negedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rejected_idle", {busy, bus.s_ready}, 0);
      @(negedge clk); #1;
    end
    bus.s_valid = 1'b0;
    chk("rejected_no_handshake", hs_count - hs0, 0);
    rand_bytes(q);
    do_load(q, SCHED_FIN, 1'b0);

    // Reset mid-load after the fifth write
    gaps = 0;
    rand_bytes(rbytes);
    model_load(rbytes, 1'b1);
    @(negedge clk); #1;
    sched_state = SCHED_IDLE; load_start = 1'b1;
    @(negedge clk); #1;
    load_start = 1'b0;
    base = wr_count;
    fork
      send(rbytes, 1'b0);
    join_none
    cyc = 0;
    while (wr_count - base < 5 && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("writes_before_reset", wr_count - base, 5);
    @(posedge clk); #1;
    rst = 1'b1; abort = 1;
    exp_q.delete();
    #1;
    chk("midload_reset_flags", {comp_en, busy, done, err, bus.ena, bus.wea, bus.s_ready}, 0);
    chk("midload_reset_addra", bus.addra, 0);
    chk("midload_reset_dina", bus.dina, 0);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b0; abort = 0;
    repeat (3) @(negedge clk);
    rand_bytes(q);
    do_load(q, SCHED_IDLE, 1'b0);

`ifdef JLOAD_CKSUM_EN
    rand_bytes(q);
    do_load(q, SCHED_IDLE, 1'b1);
    rand_bytes(q);
    do_load(q, SCHED_FIN, 1'b0);
`endif

    // WIDTH=8, N=3: one write per byte
    q = {};
    sum2 = 8'd0;
    for (int i = 0; i < TOTAL2; i++) begin
      bytes2[i] = 8'($urandom);
      q.push_back(bytes2[i]);
      sum2 += bytes2[i];
    end
`ifdef JLOAD_CKSUM_EN
    q.push_back(sum2);
`endif
    gaps = 1;
    @(negedge clk); #1;
    sched_state = SCHED_IDLE; load2 = 1'b1;
    @(negedge clk); #1;
    load2 = 1'b0;
    send(q, 1'b1);
    wait_idle(1'b1);
    chk("w8_writes", w2cnt, TOTAL2);
    chk("w8_comp_count", c2count, 1);
    chk("w8_done", {done2, err2}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
